mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the core's instruction-fetch requester and its data-memory requester.
- Sits between the pipelined MIPS core and the memory. It generates per-requester stall signals that feed the core's stall_f / stall_d logic.
- Data accesses have priority, because they come from the older instruction in MEM. A bounded streak counter guarantees forward progress for fetch.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port.
- DATA_W, 32, data width.
- MAX_D_STREAK, 4, maximum consecutive data grants while fetch is waiting; must be >=1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- i_req  input  1  fetch request; held until i_done.
- i_addr  input  ADDR_W  fetch address; stable while i_req is high.
- i_rdata  output  DATA_W  fetched word; valid in the i_done cycle.
- i_done  output  1  one-cycle fetch completion pulse.
- i_stall  output  1  i_req & ~i_done (combinational).
- d_req  input  1  data request; held until d_done.
- d_we  input  1  1 = write, 0 = read.
- d_addr  input  ADDR_W  data address; stable while d_req is high.
- d_wdata  input  DATA_W  write data.
- d_rdata  output  DATA_W  read data; valid in the d_done cycle.
- d_done  output  1  one-cycle data completion pulse.
- d_stall  output  1  d_req & ~d_done (combinational).
- mem_req  output  1  memory access request.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data; valid when mem_ready is high.
- mem_ready  input  1  access complete, sampled while mem_req is high.

Behaviour:
- Reset values: FSM=IDLE, streak=0. All outputs are 0: mem_req, mem_we, mem_addr, mem_wdata, i_done, d_done, i_rdata, d_rdata.
- FSM states:
  - IDLE: no access in flight.
  - I_ACC: fetch access in flight.
  - D_ACC: data access in flight.
- Grant decision (in IDLE, evaluated at edge N):
  - d_req & ~(i_req & streak==MAX_D_STREAK) -> D_ACC.
  - else i_req -> I_ACC.
  - else stay in IDLE.
- On grant, register the winner's address, we and wdata onto the mem_* outputs. mem_req goes high from cycle N+1. Fetch always drives mem_we=0.
- In I_ACC/D_ACC, mem_req and the mem_* outputs are held constant until mem_ready=1 at edge M (M>=N+1). On edge M:
  - capture mem_rdata into i_rdata or d_rdata;
  - pulse the matching done in cycle M+1;
  - drop mem_req;
  - return to IDLE.
- A data write leaves d_rdata unchanged but still pulses d_done.
- Minimum latency from request to done is 2 cycles (grant edge, then ready edge). One IDLE cycle separates back-to-back accesses. A new grant may be issued in the done cycle.
- Streak counter:
  - +1 on each data grant while i_req=1, saturating at MAX_D_STREAK;
  - cleared on any fetch grant;
  - cleared on any cycle where i_req=0.
- Simultaneous i_req and d_req with streak<MAX -> data wins; fetch is granted by the (MAX_D_STREAK+1)th grant at the latest.
- The done pulses are mutually exclusive and never last more than one cycle.
- mem_ready while mem_req=0 is ignored.
- A requester that drops req mid-access is a protocol violation. The access still completes and done still pulses.
- reset asserted mid-access: asynchronous return to reset values (mem_req drops immediately). The memory must tolerate the abandoned request.

Optional Feature:
- Macro: MEM_ARB_IBUF_EN.
- Defined: a one-entry fetch buffer {valid, addr, data}.
  - Filled on every completed fetch.
  - Fetch grant in IDLE with valid & i_addr==buf_addr is a hit: no memory access, FSM stays in IDLE, i_done pulses in the next cycle with buffer data, streak is cleared.
  - A data grant with d_we=1 and d_addr==buf_addr clears valid at the grant edge. A hit check in the same cycle as such a grant is not possible, because data wins.
  - Reset clears valid.
- Undefined: no buffer; every fetch accesses memory.

Decomposition:
- Package mem_arb_pkg holds:
  - arb_state_t enum {IDLE, I_ACC, D_ACC};
  - default width constants ARB_ADDR_W=32, ARB_DATA_W=32.
- Sub-module mem_arb_ibuf (only under MEM_ARB_IBUF_EN): holds the fetch buffer and produces hit, data and fill/invalidate ports.
- The FSM and the streak counter stay in the top level.

Test Plan:
- Isolated fetch: i_req with i_addr=0x0000_0040; mem_ready 3 cycles after mem_req; mem_rdata=0x2010_0005 -> one mem_req with mem_we=0; i_done for 1 cycle with i_rdata=0x2010_0005; i_stall high until then.
- Data write then read: write d_addr=0x0000_0054, d_wdata=0xDEAD_BEEF, then read the same address; memory model returns the stored value -> mem_we=1 then 0; d_rdata=0xDEAD_BEEF; d_rdata unchanged after the write's d_done.
- Collision: i_req and d_req rise together -> data access first. Fetch follows after exactly one IDLE cycle. i_done never overlaps d_done.
- Starvation: i_req held; d_req re-asserted after every d_done for 10 accesses; MAX_D_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I; streak reads 0 after each fetch grant.
- Reset mid-access: reset low 2 cycles after mem_req rises -> mem_req=0 and all outputs 0 asynchronously. After release, a fresh fetch completes normally.
- MEM_ARB_IBUF_EN: fetch 0x0000_0080 twice -> second access shows no mem_req and i_done 1 cycle after i_req. Then write 0x0000_0080 and fetch it again -> memory access occurs.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and default widths for the memory port arbiter
package mem_arb_pkg;

   localparam int ARB_ADDR_W = 32;
   localparam int ARB_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      I_ACC = 2'd1,
      D_ACC = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory port bundle of the arbiter
interface mem_port_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ARB_ADDR_W,
   parameter int DATA_W = ARB_DATA_W
);

   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic [DATA_W-1:0] i_rdata;
   logic              i_done;
   logic              i_stall;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_done;
   logic              d_stall;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   // Arbiter side
   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
      output i_rdata, i_done, i_stall, d_rdata, d_done, d_stall,
             mem_req, mem_we, mem_addr, mem_wdata
   );

   // Core plus memory side
   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
      input  i_rdata, i_done, i_stall, d_rdata, d_done, d_stall,
             mem_req, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/mem_arb_ibuf.sv
// rtl/mem_arb_ibuf.sv - one-entry fetch buffer, built only with MEM_ARB_IBUF_EN
`ifdef MEM_ARB_IBUF_EN
module mem_arb_ibuf
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ARB_ADDR_W,
   parameter int DATA_W = ARB_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fill_i,
   input  logic [ADDR_W-1:0] fill_addr_i,
   input  logic [DATA_W-1:0] fill_data_i,
   input  logic              inv_i,
   input  logic [ADDR_W-1:0] inv_addr_i,
   input  logic [ADDR_W-1:0] lookup_addr_i,
   output logic              hit_o,
   output logic [DATA_W-1:0] data_o
);

   logic              valid_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else if (fill_i) begin
         valid_q <= 1'b1;
         addr_q  <= fill_addr_i;
         data_q  <= fill_data_i;
      end else if (inv_i && (inv_addr_i == addr_q)) begin
         // A store to the buffered word makes the copy stale
         valid_q <= 1'b0;
      end
   end

   assign hit_o  = valid_q && (lookup_addr_i == addr_q);
   assign data_o = data_q;

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - data-priority arbiter sharing one memory port between fetch and data
// Optional one-entry fetch buffer enabled by MEM_ARB_IBUF_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = ARB_ADDR_W,
   parameter int DATA_W       = ARB_DATA_W,
   parameter int MAX_D_STREAK = 4
) (
   input  logic         clk,
   input  logic         reset,
   mem_port_arbiter_if.slave bus
);

   localparam int             SW         = $clog2(MAX_D_STREAK + 1);
   localparam logic [SW-1:0]  STREAK_MAX = SW'(MAX_D_STREAK);

   arb_state_t        state_q;
   logic [SW-1:0]     streak_q, streak_d;
   logic              mem_req_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [DATA_W-1:0] i_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;
   logic              i_done_q;
   logic              d_done_q;

   logic              d_win;
   logic              i_win;
   logic              i_hit;
   logic [DATA_W-1:0] hit_data;

   // Data wins unless fetch has already waited out a full streak
   always_comb begin
      d_win = bus.d_req && !(bus.i_req && (streak_q == STREAK_MAX));
      i_win = !d_win && bus.i_req;
   end

`ifdef MEM_ARB_IBUF_EN
   logic buf_hit;
   logic buf_fill;
   logic buf_inv;

   assign buf_fill = (state_q == I_ACC) && bus.mem_ready;
   assign buf_inv  = (state_q == IDLE) && d_win && bus.d_we;

   mem_arb_ibuf #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ibuf (
      .clk           (clk),
      .reset         (reset),
      .fill_i        (buf_fill),
      .fill_addr_i   (mem_addr_q),
      .fill_data_i   (bus.mem_rdata),
      .inv_i         (buf_inv),
      .inv_addr_i    (bus.d_addr),
      .lookup_addr_i (bus.i_addr),
      .hit_o         (buf_hit),
      .data_o        (hit_data)
   );

   // A fetch still held in its own done cycle must not hit twice in a row
   assign i_hit = buf_hit && !i_done_q;
`else
   assign i_hit    = 1'b0;
   assign hit_data = '0;
`endif

   always_comb begin
      streak_d = streak_q;
      if (!bus.i_req) begin
         streak_d = '0;
      end else if (state_q == IDLE) begin
         if (d_win) begin
            if (streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
         end else begin
            streak_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         streak_q    <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         i_done_q    <= 1'b0;
         d_done_q    <= 1'b0;
      end else begin
         streak_q <= streak_d;
         i_done_q <= 1'b0;
         d_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (d_win) begin
                  state_q     <= D_ACC;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= bus.d_we;
                  mem_addr_q  <= bus.d_addr;
                  mem_wdata_q <= bus.d_wdata;
               end else if (i_win) begin
                  if (i_hit) begin
                     i_done_q  <= 1'b1;
                     i_rdata_q <= hit_data;
                  end else begin
                     state_q     <= I_ACC;
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= 1'b0;
                     mem_addr_q  <= bus.i_addr;
                     mem_wdata_q <= '0;
                  end
               end
            end
            I_ACC: begin
               if (bus.mem_ready) begin
                  state_q   <= IDLE;
                  mem_req_q <= 1'b0;
                  i_rdata_q <= bus.mem_rdata;
                  i_done_q  <= 1'b1;
               end
            end
            D_ACC: begin
               if (bus.mem_ready) begin
                  state_q   <= IDLE;
                  mem_req_q <= 1'b0;
                  if (!mem_we_q) d_rdata_q <= bus.mem_rdata;
                  d_done_q  <= 1'b1;
               end
            end
            default: begin
               state_q   <= IDLE;
               mem_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.i_rdata   = i_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.i_done    = i_done_q;
   assign bus.d_done    = d_done_q;
   assign bus.i_stall   = bus.i_req && !i_done_q;
   assign bus.d_stall   = bus.d_req && !d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   typedef struct packed {
      logic        we;
      logic        fetch;
      logic [31:0] addr;
   } grant_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   mem_port_arbiter_if bus ();

   mem_port_arbiter #(.MAX_D_STREAK(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   int n_acc = 0;
   int lat   = 3;
   int cnt   = 0;
   logic [31:0] last_d = 32'h0;
   logic [31:0] mem [logic [31:0]];
   grant_t      exp_g [$];
   logic [31:0] exp_i [$];
   logic [31:0] exp_d [$];
   grant_t      g_mon;
   logic        prev_req = 1'b0;
   logic        prev_i_done = 1'b0;
   logic        prev_d_done = 1'b0;
   logic [31:0] held_addr = 32'h0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Memory model: answers lat cycles after mem_req, writes/reads on that cycle
   always @(negedge clk) begin
      if (!reset) begin
         bus.mem_ready = 1'b0;
         bus.mem_rdata = 32'h0;
         cnt = 0;
      end else if (bus.mem_ready) begin
         bus.mem_ready = 1'b0;
         cnt = 0;
      end else if (bus.mem_req) begin
         cnt++;
         if (cnt >= lat) begin
            bus.mem_ready = 1'b1;
            if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
            else bus.mem_rdata = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 32'h0;
         end
      end
   end

   // Output monitor: pops scoreboard entries on done pulses and grants
   always @(posedge clk) begin
      #1;
      if (reset) begin
         if (bus.i_done || bus.d_done) check("done_excl", bus.i_done & bus.d_done, 0);
         if (bus.i_done) begin
            check("i_done_width", prev_i_done, 0);
            if (exp_i.size() == 0) check("i_done_unexpected", bus.i_done, 0);
            else check("i_rdata", bus.i_rdata, exp_i.pop_front());
         end
         if (bus.d_done) begin
            check("d_done_width", prev_d_done, 0);
            if (exp_d.size() == 0) check("d_done_unexpected", bus.d_done, 0);
            else check("d_rdata", bus.d_rdata, exp_d.pop_front());
         end
         if (bus.mem_req && !prev_req) begin
            n_acc++;
            held_addr = bus.mem_addr;
            if (exp_g.size() == 0) check("grant_unexpected", bus.mem_req, 0);
            else begin
               g_mon = exp_g.pop_front();
               check("grant_addr", bus.mem_addr, g_mon.addr);
               check("grant_we", bus.mem_we, g_mon.we);
               if (g_mon.fetch) check("streak_after_i", dut.streak_q, 0);
            end
         end else if (bus.mem_req && prev_req) begin
            check("mem_addr_hold", bus.mem_addr, held_addr);
         end
         prev_req    = bus.mem_req;
         prev_i_done = bus.i_done;
         prev_d_done = bus.d_done;
      end else begin
         prev_req    = 1'b0;
         prev_i_done = 1'b0;
         prev_d_done = 1'b0;
      end
   end

   task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data, input bit via_mem);
      if (via_mem) begin
         mem[addr] = data;
         exp_g.push_back(grant_t'{we: 1'b0, fetch: 1'b1, addr: addr});
      end
      exp_i.push_back(data);
      bus.i_addr = addr;
      bus.i_req  = 1'b1;
      for (int c = 0; c < 50; c++) begin
         tick();
         if (bus.i_done) break;
         check("i_stall_wait", bus.i_stall, 1);
      end
      check("i_done_seen", bus.i_done, 1);
      check("i_stall_done", bus.i_stall, 0);
      bus.i_req = 1'b0;
   endtask

   task automatic do_data(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata);
      exp_g.push_back(grant_t'{we: we, fetch: 1'b0, addr: addr});
      exp_d.push_back(rdata);
      bus.d_we    = we;
      bus.d_addr  = addr;
      bus.d_wdata = wdata;
      bus.d_req   = 1'b1;
      for (int c = 0; c < 50; c++) begin
         tick();
         if (bus.d_done) break;
         check("d_stall_wait", bus.d_stall, 1);
      end
      check("d_done_seen", bus.d_done, 1);
      bus.d_req = 1'b0;
   endtask

   initial begin
      int a0, cd, ci, k_d, k_i;
      bus.i_req = 1'b0; bus.i_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

      tick(); tick();
      check("rst_state", dut.state_q, IDLE);
      check("rst_streak", dut.streak_q, 0);
      check("rst_mem_req", bus.mem_req, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_rdata", {bus.i_rdata, bus.d_rdata}, 0);
      check("rst_done", {bus.i_done, bus.d_done, bus.mem_we}, 0);
      reset = 1'b1;
      tick();

      // Isolated fetch
      lat = 3;
      a0 = n_acc;
      do_fetch(32'h0000_0040, 32'h2010_0005, 1'b1);
      check("iso_one_access", n_acc - a0, 1);
      tick();

      // Data write then read back, then another write keeps d_rdata
      lat = 2;
      do_data(1'b1, 32'h0000_0054, 32'hDEAD_BEEF, last_d);
      tick();
      do_data(1'b0, 32'h0000_0054, 32'h0, 32'hDEAD_BEEF);
      last_d = 32'hDEAD_BEEF;
      tick();
      do_data(1'b1, 32'h0000_0058, 32'h0000_1234, last_d);
      tick();

      // Collision: data first, fetch one IDLE cycle later
      mem[32'h120] = 32'h1200_0120;
      mem[32'h220] = 32'h2200_0220;
      exp_g.push_back(grant_t'{we: 1'b0, fetch: 1'b0, addr: 32'h220});
      exp_g.push_back(grant_t'{we: 1'b0, fetch: 1'b1, addr: 32'h120});
      exp_d.push_back(32'h2200_0220);
      exp_i.push_back(32'h1200_0120);
      last_d = 32'h2200_0220;
      bus.d_we = 1'b0; bus.d_addr = 32'h220; bus.i_addr = 32'h120;
      bus.d_req = 1'b1; bus.i_req = 1'b1;
      cd = -1; ci = -1;
      for (int c = 0; c < 60; c++) begin
         tick();
         if (bus.d_done) begin cd = c; bus.d_req = 1'b0; end
         if (bus.mem_req && !bus.mem_we && bus.mem_addr == 32'h120 && ci < 0) ci = c;
         if (bus.i_done) begin bus.i_req = 1'b0; break; end
      end
      check("coll_i_done", bus.i_done, 1);
      check("coll_gap", ci - cd, 1);
      bus.i_req = 1'b0; bus.d_req = 1'b0;
      tick();

      // Starvation: both held, expect D,D,D,D,I,D,D,D,D,I
      lat = 1;
      for (int k = 0; k < 8; k++) begin
         mem[32'h200 + 4 * k] = 32'hA000_0000 + k;
         exp_d.push_back(32'hA000_0000 + k);
      end
      mem[32'h100] = 32'hB000_0100;
      mem[32'h104] = 32'hB000_0104;
      exp_i.push_back(32'hB000_0100);
      exp_i.push_back(32'hB000_0104);
      for (int k = 0; k < 10; k++) begin
         if (k == 4) exp_g.push_back(grant_t'{we: 1'b0, fetch: 1'b1, addr: 32'h100});
         else if (k == 9) exp_g.push_back(grant_t'{we: 1'b0, fetch: 1'b1, addr: 32'h104});
         else exp_g.push_back(grant_t'{we: 1'b0, fetch: 1'b0,
                                       addr: 32'h200 + 4 * (k < 4 ? k : k - 1)});
      end
      last_d = 32'hA000_0007;
      k_d = 0; k_i = 0;
      bus.d_we = 1'b0; bus.d_addr = 32'h200; bus.i_addr = 32'h100;
      bus.d_req = 1'b1; bus.i_req = 1'b1;
      for (int c = 0; c < 200; c++) begin
         tick();
         if (bus.d_done) begin
            k_d++;
            if (k_d == 8) bus.d_req = 1'b0;
            else bus.d_addr = 32'h200 + 4 * k_d;
         end
         if (bus.i_done) begin
            k_i++;
            if (k_i == 2) bus.i_req = 1'b0;
            else bus.i_addr = 32'h104;
         end
         if (k_d == 8 && k_i == 2) break;
      end
      check("starve_d_count", k_d, 8);
      check("starve_i_count", k_i, 2);
      bus.i_req = 1'b0; bus.d_req = 1'b0;
      tick();

`ifdef MEM_ARB_IBUF_EN
      // Fetch buffer: hit, then invalidate by store
      lat = 2;
      do_fetch(32'h0000_0080, 32'h1111_2222, 1'b1);
      tick();
      exp_i.push_back(32'h1111_2222);
      bus.i_addr = 32'h0000_0080;
      bus.i_req  = 1'b1;
      tick();
      check("hit_done", bus.i_done, 1);
      check("hit_no_mem_req", bus.mem_req, 0);
      bus.i_req = 1'b0;
      tick();
      do_data(1'b1, 32'h0000_0080, 32'h3333_4444, last_d);
      tick();
      a0 = n_acc;
      do_fetch(32'h0000_0080, 32'h3333_4444, 1'b1);
      check("inv_refetch_access", n_acc - a0, 1);
      tick();
`endif

      // Reset mid-access
      lat = 10;
      exp_g.push_back(grant_t'{we: 1'b0, fetch: 1'b1, addr: 32'h300});
      bus.i_addr = 32'h300;
      bus.i_req  = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (bus.mem_req) break;
      end
      check("rst_req_seen", bus.mem_req, 1);
      tick(); tick();
      #2 reset = 1'b0;
      #1;
      check("async_mem_req", bus.mem_req, 0);
      check("async_mem_addr", bus.mem_addr, 0);
      check("async_rdata", {bus.i_rdata, bus.d_rdata}, 0);
      check("async_misc", {bus.mem_we, bus.mem_wdata, bus.i_done, bus.d_done}, 0);
      bus.i_req = 1'b0;
      last_d = 32'h0;
      tick(); tick();
      reset = 1'b1;
      lat = 1;
      tick();
      do_fetch(32'h0000_0304, 32'hCAFE_0001, 1'b1);
      tick(); tick();

      check("sb_grants_left", exp_g.size(), 0);
      check("sb_i_left", exp_i.size(), 0);
      check("sb_d_left", exp_d.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
